// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of the matrix ALU: accepts one command, pulses
// alu_start, waits for a fixed settle time or for alu_done, then holds the response.
module alu_op_sequencer #(
  parameter int DATA_W    = 200,
  parameter int COMB_WAIT = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_size,
  input  logic [7:0]        cmd_scalar,
  input  logic [DATA_W-1:0] cmd_matrix_a,
  input  logic [DATA_W-1:0] cmd_matrix_b,
  output logic [2:0]        alu_op_code,
  output logic [1:0]        alu_matrix_size,
  output logic [DATA_W-1:0] alu_matrix_a,
  output logic [DATA_W-1:0] alu_matrix_b,
  output logic [7:0]        alu_scalar,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  input  logic              alu_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_error,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] COMB_LAST = CNT_W'(COMB_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] OP_DET     = 3'b101;
  localparam logic [2:0] OP_MULT    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_low_q, seen_low_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               accept;
  logic               is_seq;

  assign is_seq = (alu_op_code == OP_DET) || (alu_op_code == OP_MULT);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_op == OP_ILLEGAL) begin
            state_d  = S_RESP;
            result_d = '0;
            ovf_d    = 1'b0;
            err_d    = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        state_d    = S_WAIT;
        cnt_d      = '0;
        seen_low_d = 1'b0;
      end
      S_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (!is_seq) begin
          if (cnt_q == COMB_LAST) begin
            state_d  = S_RESP;
            result_d = alu_result;
            ovf_d    = alu_overflow;
            err_d    = 1'b0;
          end
        end else begin
          // A done still high from a previous operation must not be taken.
          if (!alu_done) seen_low_d = 1'b1;
          if (alu_done && seen_low_q) begin
            state_d  = S_RESP;
            result_d = alu_result;
            ovf_d    = alu_overflow;
            err_d    = 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_d  = S_RESP;
            result_d = '0;
            ovf_d    = 1'b0;
            err_d    = 1'b1;
          end
        end
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the wide operand registers are reset because their outputs must
  // read zero during reset; plain data storage would normally skip the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_op_code     <= '0;
      alu_matrix_size <= '0;
      alu_scalar      <= '0;
      alu_matrix_a    <= '0;
      alu_matrix_b    <= '0;
    end else if (accept) begin
      alu_op_code     <= cmd_op;
      alu_matrix_size <= cmd_size;
      alu_scalar      <= cmd_scalar;
      alu_matrix_a    <= cmd_matrix_a;
      alu_matrix_b    <= cmd_matrix_b;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign alu_start    = (state_q == S_START);
  assign rsp_valid    = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign rsp_result   = result_q;
  assign rsp_overflow = ovf_q;
  assign rsp_error    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: handshake timing, stale-done guard,
// timeout, illegal op, response back-pressure and mid-operation reset.
module tb_alu_op_sequencer;

  localparam int DATA_W = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [2:0]        cmd_op;
  logic [1:0]        cmd_size;
  logic [7:0]        cmd_scalar;
  logic [DATA_W-1:0] cmd_matrix_a, cmd_matrix_b;
  logic [2:0]        alu_op_code;
  logic [1:0]        alu_matrix_size;
  logic [DATA_W-1:0] alu_matrix_a, alu_matrix_b;
  logic [7:0]        alu_scalar;
  logic              alu_start;
  logic [DATA_W-1:0] alu_result, alu_result_r;
  logic              alu_overflow, alu_done;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_overflow, rsp_error, busy;
  logic              model_en;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.DATA_W(DATA_W), .COMB_WAIT(1), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_size(cmd_size), .cmd_scalar(cmd_scalar),
    .cmd_matrix_a(cmd_matrix_a), .cmd_matrix_b(cmd_matrix_b),
    .alu_op_code(alu_op_code), .alu_matrix_size(alu_matrix_size),
    .alu_matrix_a(alu_matrix_a), .alu_matrix_b(alu_matrix_b),
    .alu_scalar(alu_scalar), .alu_start(alu_start),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] fill(input logic [7:0] b);
    return {25{b}};
  endfunction

  // Byte-wise adder standing in for the ALU, fed from the registered operands.
  function automatic logic [DATA_W-1:0] byte_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 25; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
    return r;
  endfunction

  always_comb alu_result = model_en ? byte_add(alu_matrix_a, alu_matrix_b) : alu_result_r;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_size     = 2'b11;
    cmd_scalar   = 8'hFE;
    cmd_matrix_a = fill(av);
    cmd_matrix_b = fill(bv);
    tick();
    cmd_valid    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_size = '0; cmd_scalar = '0;
    cmd_matrix_a = '0; cmd_matrix_b = '0; alu_result_r = '0; alu_overflow = 1'b0;
    alu_done = 1'b0; rsp_ready = 1'b1; model_en = 1'b0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alu_start", alu_start, 0);
    check("reset_alu_a", alu_matrix_a, 0);
    check("reset_rsp_result", rsp_result, 0);
    #6 rst = 1'b1;
    tick();
    check("idle_cmd_ready", cmd_ready, 1);

    // Add: response four edges after accept.
    model_en = 1'b1;
    send(3'b000, 8'd3, 8'd4);
    check("add_load_busy", busy, 1);
    check("add_load_start", alu_start, 0);
    check("add_load_a", alu_matrix_a, fill(8'd3));
    check("add_load_scalar", alu_scalar, 8'hFE);
    tick();
    check("add_start_pulse", alu_start, 1);
    tick();
    check("add_wait_start_low", alu_start, 0);
    check("add_wait_no_rsp", rsp_valid, 0);
    tick();
    check("add_rsp_valid", rsp_valid, 1);
    check("add_result", rsp_result, fill(8'd7));
    check("add_overflow", rsp_overflow, 0);
    check("add_error", rsp_error, 0);
    tick();
    check("add_done_rsp_low", rsp_valid, 0);
    check("add_done_ready", cmd_ready, 1);

    // Illegal op: straight to response with error, no start pulse.
    model_en = 1'b0;
    alu_result_r = fill(8'h55);
    send(3'b111, 8'd1, 8'd1);
    check("ill_rsp_valid", rsp_valid, 1);
    check("ill_error", rsp_error, 1);
    check("ill_result", rsp_result, 0);
    check("ill_no_start", alu_start, 0);
    tick();
    check("ill_idle", cmd_ready, 1);

    // Mult: done already high at start must be ignored until it has gone low.
    alu_done = 1'b1;
    alu_result_r = fill(8'd1);
    send(3'b110, 8'd2, 8'd2);
    tick();
    tick();
    tick();
    check("mult_stale_ignored", rsp_valid, 0);
    alu_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mult_waiting", rsp_valid, 0);
    alu_done = 1'b1;
    alu_overflow = 1'b1;
    alu_result_r = fill(8'd9);
    tick();
    check("mult_rsp_valid", rsp_valid, 1);
    check("mult_result", rsp_result, fill(8'd9));
    check("mult_overflow", rsp_overflow, 1);
    check("mult_error", rsp_error, 0);
    alu_done = 1'b0;
    alu_overflow = 1'b0;
    tick();

    // Det timeout: 64 WAIT cycles with no done.
    alu_result_r = fill(8'd5);
    send(3'b101, 8'd1, 8'd1);
    tick();
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("det_still_waiting", rsp_valid, 0);
    tick();
    check("det_rsp_valid", rsp_valid, 1);
    check("det_error", rsp_error, 1);
    check("det_result", rsp_result, 0);
    tick();

    // Back-pressure: response held while rsp_ready is low.
    model_en = 1'b1;
    rsp_ready = 1'b0;
    send(3'b000, 8'd10, 8'd20);
    tick();
    tick();
    tick();
    model_en = 1'b0;
    alu_result_r = fill(8'd99);
    cmd_valid = 1'b1;
    cmd_op = 3'b001;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_result_stable", rsp_result, fill(8'd30));
      check("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    check("bp_op_not_taken", alu_op_code, 3'b000);
    rsp_ready = 1'b1;
    tick();
    check("bp_handshake_idle", cmd_ready, 1);
    check("bp_op_still_old", alu_op_code, 3'b000);
    tick();
    cmd_valid = 1'b0;
    check("bp_second_accept", alu_op_code, 3'b001);
    alu_result_r = fill(8'd2);
    tick();
    tick();
    tick();
    check("sub_result", rsp_result, fill(8'd2));
    tick();

    // Reset during WAIT of a mult aborts the command.
    send(3'b110, 8'd6, 8'd6);
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_op", alu_op_code, 0);
    check("rst_alu_a", alu_matrix_a, 0);
    #2 rst = 1'b1;
    tick();
    check("rst_no_rsp", rsp_valid, 0);
    model_en = 1'b1;
    send(3'b000, 8'd1, 8'd2);
    tick();
    tick();
    tick();
    check("post_rst_rsp_valid", rsp_valid, 1);
    check("post_rst_result", rsp_result, fill(8'd3));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
